// File: rtl/lfsr_pkg.sv
// Shared constants for the 11-bit pseudo-random sequence generator.
package lfsr_pkg;
    localparam int                    LFSR_WIDTH         = 11;
    localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_TAPS  = 11'h500;
    localparam logic [LFSR_WIDTH-1:0] LFSR_ZERO_SEED_SUB = 11'h001;
endpackage

// File: rtl/lfsr_11_bit.sv
// Free-running Fibonacci LFSR (x^11 + x^9 + 1 by default) with a seed
// loaded on synchronous reset; a zero seed is replaced to avoid lock-up.
module lfsr_11_bit
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] TAP_MASK = LFSR_DEFAULT_TAPS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] out
);

    logic [LFSR_WIDTH-1:0] out_q;
    logic [LFSR_WIDTH-1:0] out_d;
    logic [LFSR_WIDTH-1:0] seed_load;
    logic                  fb;

    always_comb begin
        fb        = ^(out_q & TAP_MASK);
        out_d     = {out_q[LFSR_WIDTH-2:0], fb};
        // The all-zero state is a fixed point of the shift, so never load it.
        seed_load = (seed == '0) ? LFSR_ZERO_SEED_SUB : seed;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= seed_load;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_lfsr_11_bit.sv
// Self-checking bench: directed sequences, full-period scoreboard and
// randomized reset/seed traffic against an arithmetic reference model.
module tb_lfsr_11_bit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] seed  = 11'h000;
    logic [10:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] model_val;
    bit          model_valid = 1'b0;
    bit          seen [2048];

    lfsr_11_bit dut (
        .clock (clock),
        .reset (reset),
        .seed  (seed),
        .out   (out)
    );

    always #5 clock = ~clock;

    // Reference: shift left by one, new LSB is the parity of the tapped bits.
    function automatic logic [10:0] model_next(input logic [10:0] s);
        int v;
        int par;
        v   = int'(s);
        par = $countones(s & 11'h500) % 2;
        return 11'(((v * 2) % 2048) + par);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            model_val   = (seed == 11'h000) ? 11'h001 : seed;
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_val = model_next(model_val);
        end
    end

    // Continuous comparison against the model on every meaningful cycle.
    always @(negedge clock) begin
        if (model_valid) begin
            n_checks++;
            if (out !== model_val) begin
                n_fail++;
                $display("FAIL model_track t=%0t out=%h required=%h", $time, out, model_val);
            end
        end
    end

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s out=%h required=%h", name, got, exp);
        end else begin
            $display("ok   %s out=%h", name, got);
        end
    endtask

    // Apply inputs at a negedge, let one rising edge pass, return just after the next negedge.
    task automatic cyc(input logic r, input logic [10:0] s);
        reset = r;
        seed  = s;
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [10:0] exp_seq [5];
        int          nseen;
        logic [10:0] rseed;

        exp_seq[0] = 11'h555; exp_seq[1] = 11'h2AA; exp_seq[2] = 11'h554;
        exp_seq[3] = 11'h2A8; exp_seq[4] = 11'h550;

        // Directed: seed 0x555 and first four advances.
        cyc(1'b1, 11'h555);
        check("reset_seed_555", out, exp_seq[0]);
        for (int i = 1; i < 5; i++) begin
            cyc(1'b0, 11'h555);
            check($sformatf("seq555_step%0d", i), out, exp_seq[i]);
        end

        // Full period with occupancy scoreboard.
        cyc(1'b1, 11'h555);
        check("period_reload", out, 11'h555);
        for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
        seen[11'h555] = 1'b1;
        for (int i = 1; i <= 2047; i++) begin
            cyc(1'b0, 11'h555);
            if (out == 11'h000) begin
                n_checks++; n_fail++;
                $display("FAIL period_zero step=%0d out=%h required=nonzero", i, out);
            end else if (seen[out] && i != 2047) begin
                n_checks++; n_fail++;
                $display("FAIL period_early_repeat step=%0d out=%h required=unseen", i, out);
            end
            seen[out] = 1'b1;
        end
        check("period_wrap", out, 11'h555);
        nseen = 0;
        for (int i = 1; i < 2048; i++) if (seen[i]) nseen++;
        n_checks++;
        if (nseen != 2047 || seen[0]) begin
            n_fail++;
            $display("FAIL period_coverage distinct=%0d required=2047", nseen);
        end

        // Zero seed is substituted.
        cyc(1'b1, 11'h000);
        check("zero_seed_sub", out, 11'h001);
        cyc(1'b0, 11'h000);
        check("zero_seed_adv1", out, 11'h002);
        cyc(1'b0, 11'h000);
        check("zero_seed_adv2", out, 11'h004);

        // Seed changes while running are ignored; mid-sequence reset reloads.
        cyc(1'b1, 11'h555);
        for (int i = 0; i < 100; i++) cyc(1'b0, 11'h555);
        for (int i = 0; i < 5; i++) cyc(1'b0, 11'h123);
        cyc(1'b1, 11'h123);
        check("mid_reset_load", out, 11'h123);
        // 0x123: bit10=0, bit8=1, so feedback is 1.
        cyc(1'b0, 11'h123);
        check("mid_reset_adv", out, 11'h247);

        // Reset held several edges keeps the seed.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 11'h7FF);
            check($sformatf("hold_7ff_%0d", i), out, 11'h7FF);
        end
        cyc(1'b0, 11'h7FF);
        check("hold_release_adv", out, 11'h7FE);

        // Randomized reset pulses and seed churn, checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            rseed = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 15) == 0) rseed = 11'h000;
            cyc(($urandom_range(0, 31) == 0), rseed);
            if (out == 11'h000) begin
                n_checks++; n_fail++;
                $display("FAIL random_nonzero cycle=%0d out=%h required=nonzero", i, out);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
